// File: rtl/fib_pkg.sv
// Shared definitions for the fibonacci generator/checker pair: FSM state codes,
// default word width and the next-term helper.
package fib_pkg;

    localparam int unsigned FIB_W = 32;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] SEED_A = 3'd0;
    localparam logic [ST_W-1:0] SEED_B = 3'd1;
    localparam logic [ST_W-1:0] TRACK  = 3'd2;
    localparam logic [ST_W-1:0] WRAP   = 3'd3;
    localparam logic [ST_W-1:0] HALT   = 3'd4;

    // Next term at the default width, carry in the MSB.
    function automatic logic [FIB_W:0] fib_next(input logic [FIB_W-1:0] prev,
                                                input logic [FIB_W-1:0] cur);
        return {1'b0, prev} + {1'b0, cur};
    endfunction

endpackage

// File: rtl/fibonacci_checker_if.sv
// Valid/ready word stream between the fibonacci generator and its checker.
interface fibonacci_checker_if
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH = FIB_W
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fib_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear beats increment.
module fib_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fibonacci_checker.sv
// Stream checker: seeds from the first two accepted words, then verifies each
// later word is the sum of the previous two; reports lock, errors and overflow.
module fibonacci_checker
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH       = FIB_W,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_N      = 4,
    parameter bit          HALT_ON_ERR = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    fibonacci_checker_if.slave bus,
    output logic               lock,
    output logic               mismatch,
    output logic               overflow,
    output logic [WIDTH-1:0]   expected,
    output logic [CNT_W-1:0]   term_count,
    output logic [CNT_W-1:0]   err_count
);

    localparam int unsigned RUN_W = $clog2(LOCK_N + 1);

    logic [ST_W-1:0]  state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             lock_q, lock_d;
    logic             mismatch_q, mismatch_d;
    logic             overflow_q, overflow_d;
    logic             ready_q, ready_d;

    logic             beat_c;
    logic             hit_c;
    logic             load_c;
    logic             err_inc_c;
    logic [WIDTH:0]   sum_c;

    assign beat_c = bus.in_valid & ready_q;
    // expected_q always holds prev+cur, so the compare needs no adder of its own.
    assign hit_c  = (bus.in_data == expected_q);

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        expected_d = expected_q;
        run_d      = run_q;
        lock_d     = lock_q;
        mismatch_d = 1'b0;
        overflow_d = overflow_q;
        load_c     = 1'b0;
        err_inc_c  = 1'b0;

        if (clear) begin
            state_d    = SEED_A;
            prev_d     = '0;
            cur_d      = '0;
            expected_d = '0;
            run_d      = '0;
            lock_d     = 1'b0;
            overflow_d = 1'b0;
        end else if (beat_c) begin
            case (state_q)
                SEED_A: begin
                    cur_d   = bus.in_data;
                    state_d = SEED_B;
                end
                SEED_B: begin
                    prev_d  = cur_q;
                    cur_d   = bus.in_data;
                    load_c  = 1'b1;
                    state_d = TRACK;
                end
                TRACK: begin
                    if (hit_c) begin
                        prev_d = cur_q;
                        cur_d  = bus.in_data;
                        load_c = 1'b1;
                        run_d  = (run_q == RUN_W'(LOCK_N)) ? run_q : run_q + RUN_W'(1);
                        lock_d = (run_d == RUN_W'(LOCK_N));
                    end else begin
                        mismatch_d = 1'b1;
                        err_inc_c  = 1'b1;
                        lock_d     = 1'b0;
                        run_d      = '0;
                        if (HALT_ON_ERR) begin
                            state_d = HALT;
                        end else begin
                            cur_d   = bus.in_data;
                            state_d = SEED_B;
                        end
                    end
                end
                default: ;
            endcase
        end

        // Next expected term, with carry out steering the FSM into WRAP.
        sum_c = {1'b0, prev_d} + {1'b0, cur_d};
        if (load_c) begin
            expected_d = sum_c[WIDTH-1:0];
            if (sum_c[WIDTH]) begin
                overflow_d = 1'b1;
                lock_d     = 1'b0;
                state_d    = WRAP;
            end
        end

        ready_d = (state_d != HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SEED_A;
            prev_q     <= '0;
            cur_q      <= '0;
            expected_q <= '0;
            run_q      <= '0;
            lock_q     <= 1'b0;
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            expected_q <= expected_d;
            run_q      <= run_d;
            lock_q     <= lock_d;
            mismatch_q <= mismatch_d;
            overflow_q <= overflow_d;
            ready_q    <= ready_d;
        end
    end

    fib_sat_counter #(.CNT_W(CNT_W)) u_term_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (beat_c),
        .count (term_count)
    );

    fib_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .inc   (err_inc_c),
        .count (err_count)
    );

    assign bus.in_ready = ready_q;
    assign lock         = lock_q;
    assign mismatch     = mismatch_q;
    assign overflow     = overflow_q;
    assign expected     = expected_q;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Bench for fibonacci_checker: three instances (resync, halt, 8-bit/4-bit counters)
// checked against a sequence-level reference model.
module tb_fibonacci_checker;

    localparam int unsigned LOCK_N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v   [3];
    logic [31:0] dat [3];
    logic        clr [3];

    int n_tests = 0;
    int n_fail  = 0;

    fibonacci_checker_if #(.WIDTH(32)) if0 ();
    fibonacci_checker_if #(.WIDTH(32)) if1 ();
    fibonacci_checker_if #(.WIDTH(8))  if2 ();

    assign if0.in_valid = v[0];
    assign if0.in_data  = dat[0];
    assign if1.in_valid = v[1];
    assign if1.in_data  = dat[1];
    assign if2.in_valid = v[2];
    assign if2.in_data  = dat[2][7:0];

    logic        l0, l1, l2, mi0, mi1, mi2, ov0, ov1, ov2;
    logic [31:0] x0, x1;
    logic [7:0]  x2;
    logic [15:0] t0, t1, e0, e1;
    logic [3:0]  t2, e2;

    fibonacci_checker #(.WIDTH(32), .CNT_W(16), .LOCK_N(LOCK_N), .HALT_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .clear(clr[0]), .bus(if0.slave), .lock(l0), .mismatch(mi0),
        .overflow(ov0), .expected(x0), .term_count(t0), .err_count(e0));
    fibonacci_checker #(.WIDTH(32), .CNT_W(16), .LOCK_N(LOCK_N), .HALT_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .clear(clr[1]), .bus(if1.slave), .lock(l1), .mismatch(mi1),
        .overflow(ov1), .expected(x1), .term_count(t1), .err_count(e1));
    fibonacci_checker #(.WIDTH(8), .CNT_W(4), .LOCK_N(LOCK_N), .HALT_ON_ERR(1'b0)) dut2 (
        .clk(clk), .rst(rst), .clear(clr[2]), .bus(if2.slave), .lock(l2), .mismatch(mi2),
        .overflow(ov2), .expected(x2), .term_count(t2), .err_count(e2));

    logic        o_lock [3], o_mis [3], o_ovf [3], o_rdy [3];
    logic [31:0] o_exp [3], o_term [3], o_err [3];

    always_comb begin
        o_lock = '{l0, l1, l2};
        o_mis  = '{mi0, mi1, mi2};
        o_ovf  = '{ov0, ov1, ov2};
        o_rdy  = '{if0.in_ready, if1.in_ready, if2.in_ready};
        o_exp  = '{x0, x1, 32'(x2)};
        o_term = '{32'(t0), 32'(t1), 32'(t2)};
        o_err  = '{32'(e0), 32'(e1), 32'(t2 & 4'h0) | 32'(e2)};
    end

    // Reference model: words seen since the last seed, run of matches, sticky flags.
    int unsigned     m_w    [3] = '{32, 32, 8};
    bit              m_halt [3] = '{1'b0, 1'b1, 1'b0};
    longint unsigned m_cmax [3] = '{65535, 65535, 15};
    longint unsigned m_a [3], m_b [3], m_term [3], m_err [3];
    int              m_n [3], m_run [3];
    bit              m_ovf [3], m_halted [3], m_mis [3];

    function automatic void model_reset(int i);
        m_a[i] = 0; m_b[i] = 0; m_n[i] = 0; m_run[i] = 0;
        m_ovf[i] = 1'b0; m_halted[i] = 1'b0; m_mis[i] = 1'b0;
        m_term[i] = 0; m_err[i] = 0;
    endfunction

    function automatic void model_step(int i);
        longint unsigned md = 64'd1 << m_w[i];
        longint unsigned d  = longint'(dat[i]) & (md - 1);
        m_mis[i] = 1'b0;
        if (clr[i]) begin
            model_reset(i);
            return;
        end
        if (!v[i] || m_halted[i]) return;
        if (m_term[i] < m_cmax[i]) m_term[i]++;
        if (m_ovf[i]) return;
        if (m_n[i] == 0) begin
            m_b[i] = d; m_n[i] = 1;
        end else if (m_n[i] == 1) begin
            m_a[i] = m_b[i]; m_b[i] = d; m_n[i] = 2;
            if (m_a[i] + m_b[i] >= md) m_ovf[i] = 1'b1;
        end else if (d == (m_a[i] + m_b[i]) % md) begin
            m_a[i] = m_b[i]; m_b[i] = d; m_run[i]++;
            if (m_a[i] + m_b[i] >= md) m_ovf[i] = 1'b1;
        end else begin
            m_mis[i] = 1'b1; m_run[i] = 0;
            if (m_err[i] < m_cmax[i]) m_err[i]++;
            if (m_halt[i]) m_halted[i] = 1'b1;
            else begin m_b[i] = d; m_n[i] = 1; end
        end
    endfunction

    function automatic logic m_lock(int i);
        return !m_ovf[i] && (m_run[i] >= LOCK_N);
    endfunction

    function automatic bit m_exp_ok(int i);
        return (m_n[i] == 2) && !m_ovf[i] && !m_halted[i];
    endfunction

    function automatic logic [31:0] m_exp(int i);
        return 32'((m_a[i] + m_b[i]) % (64'd1 << m_w[i]));
    endfunction

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin v[i] = 1'b0; dat[i] = '0; clr[i] = 1'b0; model_reset(i); end
        #2;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({o_rdy[i], o_lock[i], o_mis[i], o_ovf[i]} !== 4'b1000) begin
                $display("FAIL reset_flags dut%0d got rdy/lock/mis/ovf=%b want 1000", i,
                         {o_rdy[i], o_lock[i], o_mis[i], o_ovf[i]}); n_fail++; end
            n_tests++;
            if ((o_exp[i] | o_term[i] | o_err[i]) !== 32'd0) begin
                $display("FAIL reset_values dut%0d got exp=%0d term=%0d err=%0d want 0", i,
                         o_exp[i], o_term[i], o_err[i]); n_fail++; end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fib_stream();
        logic [31:0] s [8];
        s = '{0, 1, 1, 2, 3, 5, 8, 13};
        for (int k = 0; k < 8; k++) begin
            v[0] = 1'b1; dat[0] = s[k];
            tick();
            n_tests++;
            if (o_mis[0] !== m_mis[0] || o_lock[0] !== m_lock(0)) begin
                $display("FAIL stream_beat%0d got mis=%b lock=%b want mis=%b lock=%b", k,
                         o_mis[0], o_lock[0], m_mis[0], m_lock(0)); n_fail++; end
            if (k == 4 || k == 5) begin
                n_tests++;
                if (o_lock[0] !== (k == 5)) begin
                    $display("FAIL stream_lock_edge beat%0d got %b want %b", k, o_lock[0], k == 5);
                    n_fail++; end
            end
        end
        v[0] = 1'b0;
        n_tests++;
        if (o_term[0] !== 32'd8 || o_err[0] !== 32'd0 || o_exp[0] !== 32'd21) begin
            $display("FAIL stream_final got term=%0d err=%0d exp=%0d want 8 0 21",
                     o_term[0], o_err[0], o_exp[0]); n_fail++; end
    endtask

    task automatic test_resync();
        logic [31:0] s [7];
        s = '{0, 1, 1, 2, 4, 6, 10};
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        for (int k = 0; k < 7; k++) begin
            v[0] = 1'b1; dat[0] = s[k];
            tick();
            n_tests++;
            if (o_mis[0] !== m_mis[0] || o_mis[0] !== (k == 4)) begin
                $display("FAIL resync_mis beat%0d got %b want %b", k, o_mis[0], m_mis[0]); n_fail++; end
            if (m_exp_ok(0)) begin
                n_tests++;
                if (o_exp[0] !== m_exp(0)) begin
                    $display("FAIL resync_exp beat%0d got %0d want %0d", k, o_exp[0], m_exp(0));
                    n_fail++; end
            end
        end
        v[0] = 1'b0;
        n_tests++;
        if (o_err[0] !== 32'd1 || o_lock[0] !== 1'b0 || o_term[0] !== 32'd7) begin
            $display("FAIL resync_final got err=%0d lock=%b term=%0d want 1 0 7",
                     o_err[0], o_lock[0], o_term[0]); n_fail++; end
    endtask

    task automatic test_halt();
        logic [31:0] s [4];
        s = '{1, 1, 2, 7};
        for (int k = 0; k < 4; k++) begin
            v[1] = 1'b1; dat[1] = s[k];
            tick();
            n_tests++;
            if (o_mis[1] !== m_mis[1]) begin
                $display("FAIL halt_mis beat%0d got %b want %b", k, o_mis[1], m_mis[1]); n_fail++; end
        end
        n_tests++;
        if (o_mis[1] !== 1'b1 || o_rdy[1] !== 1'b0) begin
            $display("FAIL halt_enter got mis=%b rdy=%b want 1 0", o_mis[1], o_rdy[1]); n_fail++; end
        dat[1] = 32'd9; tick(); tick();
        n_tests++;
        if (o_term[1] !== 32'(m_term[1]) || o_term[1] !== 32'd4 || o_rdy[1] !== 1'b0) begin
            $display("FAIL halt_hold got term=%0d rdy=%b want 4 0", o_term[1], o_rdy[1]); n_fail++; end
        clr[1] = 1'b1; tick(); clr[1] = 1'b0;
        n_tests++;
        if (o_rdy[1] !== 1'b1 || o_term[1] !== 32'd0 || o_err[1] !== 32'd0) begin
            $display("FAIL halt_clear got rdy=%b term=%0d err=%0d want 1 0 0",
                     o_rdy[1], o_term[1], o_err[1]); n_fail++; end
        dat[1] = 32'd5; tick();
        dat[1] = 32'd6; tick();
        n_tests++;
        if (o_exp[1] !== 32'd11 || o_exp[1] !== m_exp(1)) begin
            $display("FAIL halt_reseed_exp got %0d want 11", o_exp[1]); n_fail++; end
        dat[1] = 32'd11; tick();
        v[1] = 1'b0;
        n_tests++;
        if (o_mis[1] !== 1'b0 || o_term[1] !== 32'd3) begin
            $display("FAIL halt_reseed_track got mis=%b term=%0d want 0 3", o_mis[1], o_term[1]);
            n_fail++; end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 18; k++) begin
            v[2] = 1'b1;
            dat[2] = (k == 0) ? 32'd89 : (k == 1) ? 32'd144 : (k == 2) ? 32'd233 : $urandom;
            tick();
            n_tests++;
            if (o_mis[2] !== 1'b0 || o_ovf[2] !== m_ovf[2] || o_lock[2] !== 1'b0 ||
                o_term[2] !== 32'(m_term[2])) begin
                $display("FAIL ovf_beat%0d got mis=%b ovf=%b lock=%b term=%0d want 0 %b 0 %0d", k,
                         o_mis[2], o_ovf[2], o_lock[2], o_term[2], m_ovf[2], m_term[2]); n_fail++; end
            if (k == 1) begin
                n_tests++;
                if (o_ovf[2] !== 1'b0 || o_exp[2] !== 32'd233) begin
                    $display("FAIL ovf_seed got ovf=%b exp=%0d want 0 233", o_ovf[2], o_exp[2]);
                    n_fail++; end
            end
            if (k == 2) begin
                n_tests++;
                if (o_ovf[2] !== 1'b1) begin
                    $display("FAIL ovf_set got %b want 1", o_ovf[2]); n_fail++; end
            end
        end
        v[2] = 1'b0;
        n_tests++;
        if (o_term[2] !== 32'd15 || o_err[2] !== 32'd0) begin
            $display("FAIL ovf_term_sat got term=%0d err=%0d want 15 0", o_term[2], o_err[2]); n_fail++; end
    endtask

    task automatic test_gaps();
        logic [31:0] s [5];
        int k = 0;
        int cyc = 0;
        s = '{2, 3, 5, 8, 13};
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        while (k < 5 && cyc < 200) begin
            v[0] = 1'($urandom_range(0, 1));
            dat[0] = $urandom;
            if (v[0]) begin dat[0] = s[k]; k++; end
            tick();
            cyc++;
            n_tests++;
            if (o_mis[0] !== 1'b0 || o_lock[0] !== m_lock(0) || o_term[0] !== 32'(m_term[0])) begin
                $display("FAIL gaps_cycle%0d got mis=%b lock=%b term=%0d want 0 %b %0d", cyc,
                         o_mis[0], o_lock[0], o_term[0], m_lock(0), m_term[0]); n_fail++; end
        end
        v[0] = 1'b0;
        n_tests++;
        if (k != 5 || o_term[0] !== 32'd5 || o_err[0] !== 32'd0 || o_lock[0] !== 1'b0 ||
            o_exp[0] !== 32'd21) begin
            $display("FAIL gaps_final got beats=%0d term=%0d err=%0d lock=%b exp=%0d want 5 5 0 0 21",
                     k, o_term[0], o_err[0], o_lock[0], o_exp[0]); n_fail++; end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                v[i]   = ($urandom_range(0, 3) != 0);
                clr[i] = ($urandom_range(0, 299) == 0);
                if (m_n[i] == 2 && $urandom_range(0, 3) != 0) dat[i] = 32'(m_a[i] + m_b[i]);
                else dat[i] = 32'($urandom_range(0, 20));
            end
            tick();
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({o_mis[i], o_lock[i], o_ovf[i], o_rdy[i]} !==
                    {m_mis[i], m_lock(i), m_ovf[i], !m_halted[i]}) begin
                    $display("FAIL rand_flags dut%0d cyc%0d got mis/lock/ovf/rdy=%b want %b", i, c,
                             {o_mis[i], o_lock[i], o_ovf[i], o_rdy[i]},
                             {m_mis[i], m_lock(i), m_ovf[i], !m_halted[i]}); n_fail++; end
                n_tests++;
                if (o_term[i] !== 32'(m_term[i]) || o_err[i] !== 32'(m_err[i])) begin
                    $display("FAIL rand_counts dut%0d cyc%0d got term=%0d err=%0d want %0d %0d", i, c,
                             o_term[i], o_err[i], m_term[i], m_err[i]); n_fail++; end
                if (m_exp_ok(i)) begin
                    n_tests++;
                    if (o_exp[i] !== m_exp(i)) begin
                        $display("FAIL rand_exp dut%0d cyc%0d got %0d want %0d", i, c, o_exp[i], m_exp(i));
                        n_fail++; end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin v[i] = 1'b0; clr[i] = 1'b0; end
    endtask

    task automatic test_async_reset();
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        v[0] = 1'b1;
        dat[0] = 32'd1; tick();
        dat[0] = 32'd2; tick();
        dat[0] = 32'd3; tick();
        dat[0] = 32'd5;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({o_rdy[0], o_lock[0], o_mis[0], o_ovf[0]} !== 4'b1000 ||
            (o_exp[0] | o_term[0] | o_err[0]) !== 32'd0) begin
            $display("FAIL async_rst got rdy/lock/mis/ovf=%b exp=%0d term=%0d err=%0d want 1000 0 0 0",
                     {o_rdy[0], o_lock[0], o_mis[0], o_ovf[0]}, o_exp[0], o_term[0], o_err[0]);
            n_fail++; end
        for (int i = 0; i < 3; i++) model_reset(i);
        @(negedge clk);
        rst = 1'b0;
        dat[0] = 32'd7;  tick();
        dat[0] = 32'd9;  tick();
        n_tests++;
        if (o_exp[0] !== 32'd16 || o_exp[0] !== m_exp(0)) begin
            $display("FAIL async_reseed_exp got %0d want 16", o_exp[0]); n_fail++; end
        dat[0] = 32'd16; tick();
        v[0] = 1'b0;
        n_tests++;
        if (o_mis[0] !== 1'b0 || o_term[0] !== 32'd3 || o_exp[0] !== 32'd25) begin
            $display("FAIL async_after got mis=%b term=%0d exp=%0d want 0 3 25",
                     o_mis[0], o_term[0], o_exp[0]); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_fib_stream();
        test_resync();
        test_halt();
        test_overflow();
        test_gaps();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
